// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers: state encoding and
// the NOP instruction word that instantiating stages use as their bubble payload.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_TWO   = 2'd2
   } ps_state_e;

   // RISC-V canonical NOP (addi x0, x0, 0)
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic two-entry (main + skid) pipeline stage with valid/ready on both sides
// and a flush that either empties the stage or loads a partially preserved bubble.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned           DATA_W          = 64,
   parameter logic [DATA_W-1:0]     BUBBLE          = '0,
   parameter logic [DATA_W-1:0]     KEEP_MASK       = {{(DATA_W/2){1'b1}}, {(DATA_W-DATA_W/2){1'b0}}},
   parameter bit                    BUBBLE_ON_FLUSH = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   ps_state_e         state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, out_valid_q;
   logic              in_fire_s, out_fire_s;

   function automatic logic [DATA_W-1:0] bubble_word(input logic [DATA_W-1:0] d);
      return (d & KEEP_MASK) | (BUBBLE & ~KEEP_MASK);
   endfunction

   assign in_fire_s  = in_valid & in_ready_q;
   assign out_fire_s = out_valid_q & out_ready;

   // Next-state and payload steering; flush overrides every handshake update
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // any current out_fire simply completes; the skid entry is abandoned
         if (BUBBLE_ON_FLUSH) begin
            state_d = PS_ONE;
            main_d  = bubble_word(in_data);
         end else begin
            state_d = PS_EMPTY;
         end
      end else begin
         case (state_q)
            PS_EMPTY: begin
               if (in_fire_s) begin
                  state_d = PS_ONE;
                  main_d  = in_data;
               end else begin
                  state_d = PS_EMPTY;
               end
            end
            PS_ONE: begin
               if (in_fire_s && out_fire_s) begin
                  main_d = in_data;
               end else if (in_fire_s) begin
                  state_d = PS_TWO;
                  skid_d  = in_data;
               end else if (out_fire_s) begin
                  state_d = PS_EMPTY;
               end else begin
                  state_d = PS_ONE;
               end
            end
            PS_TWO: begin
               if (out_fire_s) begin
                  state_d = PS_ONE;
                  main_d  = skid_q;
               end else begin
                  state_d = PS_TWO;
               end
            end
            default: begin
               state_d = PS_EMPTY;
            end
         endcase
      end
   end

   // State, payload and decoded handshake registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PS_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= (state_d != PS_TWO);
         out_valid_q <= (state_d != PS_EMPTY);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table for streaming, back-pressure
// and flush behaviour, plus hand sequences for async reset and flush corners.
module tb_pipe_stage_reg;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;

   logic        ir0, ov0, ir1, ov1;
   logic [63:0] od0, od1;
   logic [1:0]  occ0, occ1;

   int n_vec = 0;
   int n_err = 0;
   int n_fire = 0;
   int head_fire = 0;
   int skid_fire = 0;

   pipe_stage_reg u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(occ0)
   );

   pipe_stage_reg #(.BUBBLE_ON_FLUSH(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count accepted outputs of the bubble-on-flush instance
   always @(posedge clk) begin
      if (rst_n && ov0 && out_ready) begin
         n_fire <= n_fire + 1;
         if (od0 == 64'h31) head_fire <= head_fire + 1;
         if (od0 == 64'h32) skid_fire <= skid_fire + 1;
      end
   end

   typedef struct {
      logic        f;
      logic        vin;
      logic [63:0] din;
      logic        ordy;
      logic        e_ov;
      logic        e_chkd;
      logic [63:0] e_dout;
      logic [1:0]  e_occ;
      logic        e_ir;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic f, logic vin, logic [63:0] din, logic ordy,
                               logic e_ov, logic e_chkd, logic [63:0] e_dout,
                               logic [1:0] e_occ, logic e_ir);
      vec_t v;
      v.f = f; v.vin = vin; v.din = din; v.ordy = ordy;
      v.e_ov = e_ov; v.e_chkd = e_chkd; v.e_dout = e_dout; v.e_occ = e_occ; v.e_ir = e_ir;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic f, input logic v, input logic [63:0] d, input logic r);
      flush = f; in_valid = v; in_data = d; out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
   endtask

   int h0, s0, f0;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b0;
      #12;
      chk("reset_ov", {63'h0, ov0}, 64'h0);
      chk("reset_occ", {62'h0, occ0}, 64'h0);
      chk("reset_ir", {63'h0, ir0}, 64'h1);
      chk("reset_dout", od0, 64'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // streaming, no gaps
      for (int k = 1; k <= 8; k++)
         vq.push_back(mk(1'b0, 1'b1, 64'(k), 1'b1, 1'b1, 1'b1, 64'(k), 2'd1, 1'b1));
      vq.push_back(mk(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0, 1'b1));
      // back-pressure and in-order release
      vq.push_back(mk(1'b0, 1'b1, 64'hA, 1'b0, 1'b1, 1'b1, 64'hA, 2'd1, 1'b1));
      vq.push_back(mk(1'b0, 1'b1, 64'hB, 1'b0, 1'b1, 1'b1, 64'hA, 2'd2, 1'b0));
      vq.push_back(mk(1'b0, 1'b1, 64'hC, 1'b0, 1'b1, 1'b1, 64'hA, 2'd2, 1'b0));
      vq.push_back(mk(1'b0, 1'b1, 64'hC, 1'b1, 1'b1, 1'b1, 64'hB, 2'd1, 1'b1));
      vq.push_back(mk(1'b0, 1'b1, 64'hC, 1'b1, 1'b1, 1'b1, 64'hC, 2'd1, 1'b1));
      vq.push_back(mk(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0, 1'b1));
      // flush with bubble from TWO; skid entry 0x22 must never surface
      vq.push_back(mk(1'b0, 1'b1, 64'h11, 1'b0, 1'b1, 1'b1, 64'h11, 2'd1, 1'b1));
      vq.push_back(mk(1'b0, 1'b1, 64'h22, 1'b0, 1'b1, 1'b1, 64'h11, 2'd2, 1'b0));
      vq.push_back(mk(1'b1, 1'b1, 64'h00400010_8C220004, 1'b0, 1'b1, 1'b1, 64'h00400010_00000000, 2'd1, 1'b1));
      vq.push_back(mk(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0, 1'b1));
      // back-to-back flushes, each a fresh bubble
      vq.push_back(mk(1'b1, 1'b1, 64'h12345678_9ABCDEF0, 1'b0, 1'b1, 1'b1, 64'h12345678_00000000, 2'd1, 1'b1));
      vq.push_back(mk(1'b1, 1'b0, 64'hCAFEF00D_DEADBEEF, 1'b0, 1'b1, 1'b1, 64'hCAFEF00D_00000000, 2'd1, 1'b1));
      vq.push_back(mk(1'b0, 1'b1, 64'h77, 1'b1, 1'b1, 1'b1, 64'h77, 2'd1, 1'b1));
      vq.push_back(mk(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0, 1'b1));

      foreach (vq[i]) begin
         drive(vq[i].f, vq[i].vin, vq[i].din, vq[i].ordy);
         chk($sformatf("v%0d_ov", i), {63'h0, ov0}, {63'h0, vq[i].e_ov});
         chk($sformatf("v%0d_occ", i), {62'h0, occ0}, {62'h0, vq[i].e_occ});
         chk($sformatf("v%0d_ir", i), {63'h0, ir0}, {63'h0, vq[i].e_ir});
         if (vq[i].e_chkd) chk($sformatf("v%0d_dout", i), od0, vq[i].e_dout);
      end

      // async reset with the stage full
      drive(1'b0, 1'b1, 64'h41, 1'b0);
      drive(1'b0, 1'b1, 64'h42, 1'b0);
      chk("pre_rst_occ", {62'h0, occ0}, 64'h2);
      rst_n = 1'b0;
      #1;
      chk("rst_ov", {63'h0, ov0}, 64'h0);
      chk("rst_occ", {62'h0, occ0}, 64'h0);
      chk("rst_ir", {63'h0, ir0}, 64'h1);
      chk("rst_dout", od0, 64'h0);
      #2;
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      chk("post_rst_ov", {63'h0, ov0}, 64'h0);

      // flush that empties a full stage
      do_reset();
      drive(1'b0, 1'b1, 64'h51, 1'b0);
      drive(1'b0, 1'b1, 64'h52, 1'b0);
      chk("nb_full_occ", {62'h0, occ1}, 64'h2);
      drive(1'b1, 1'b1, 64'h53, 1'b0);
      chk("nb_flush_occ", {62'h0, occ1}, 64'h0);
      chk("nb_flush_ov", {63'h0, ov1}, 64'h0);
      chk("nb_flush_ir", {63'h0, ir1}, 64'h1);
      chk("b_flush_dout", od0, 64'h0);
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      chk("nb_stay_empty", {63'h0, ov1}, 64'h0);

      // flush coinciding with a head fire in TWO
      do_reset();
      drive(1'b0, 1'b1, 64'h31, 1'b0);
      drive(1'b0, 1'b1, 64'h32, 1'b0);
      chk("t6_full_occ", {62'h0, occ0}, 64'h2);
      h0 = head_fire; s0 = skid_fire; f0 = n_fire;
      drive(1'b1, 1'b1, 64'hAAAABBBB_CCCCDDDD, 1'b1);
      chk("t6_bubble", od0, 64'hAAAABBBB_00000000);
      chk("t6_occ", {62'h0, occ0}, 64'h1);
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      chk("t6_empty", {63'h0, ov0}, 64'h0);
      chk("t6_head_fires", 64'(head_fire - h0), 64'h1);
      chk("t6_skid_fires", 64'(skid_fire - s0), 64'h0);
      chk("t6_total_fires", 64'(n_fire - f0), 64'h2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
